meas_osc_array: RTL

Multi-channel, fully synchronous ring-oscillator frequency meter for the PUF array. It samples `C_NCH` free-running oscillator outputs in the `I_clk` domain and counts rising edges per channel over a programmable window of `I_clk` cycles. It presents the counts with a valid/ack handshake and reports a per-channel overflow flag. It replaces the single-channel, reset-gated counter in the measurement path feeding response extraction.

---
 rtl/meas_osc_array.sv | 128 ++++++++++++
 1 files changed

// File: rtl/meas_osc_array.sv
// Multi-channel ring-oscillator frequency meter: counts synchronized rising edges per channel over a window.
// Optional pairwise response comparators are built when MEAS_OSC_CMP_EN is defined.
module meas_osc_array #(
   parameter int C_NCH    = 8,
   parameter int C_DWIDTH = 24,
   parameter int C_WWIDTH = 20
) (
   input  logic                        I_clk,
   input  logic                        I_rst,
   input  logic [C_NCH-1:0]            I_osc,
   input  logic                        I_start,
   input  logic [C_WWIDTH-1:0]         I_win_len,
   input  logic                        I_ack,
   output logic                        O_busy,
   output logic                        O_valid,
   output logic [C_NCH*C_DWIDTH-1:0]   O_data,
   output logic [C_NCH-1:0]            O_ovf,
   output logic [C_NCH-2:0]            O_resp
);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

   state_t                    state;
   logic [C_NCH-1:0]          sync1, sync2, hist, edge_det;
   logic [C_DWIDTH-1:0]       cnt     [C_NCH];
   logic [C_DWIDTH-1:0]       cnt_nxt [C_NCH];
   logic [C_NCH-1:0]          ovf_w, ovf_nxt;
   logic [C_NCH*C_DWIDTH-1:0] data_nxt;
   logic [C_WWIDTH-1:0]       win_cnt;
   logic                      finish;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
      end else begin
         sync1 <= I_osc;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign edge_det = sync2 & ~hist;

   // Last window cycle; a zero-length window also lands here after one pass with counting suppressed.
   assign finish = (state == S_COUNT) && (win_cnt[C_WWIDTH-1:1] == '0);

   always_comb begin
      data_nxt = '0;
      ovf_nxt  = ovf_w;
      for (int unsigned i = 0; i < C_NCH; i++) begin
         cnt_nxt[i] = cnt[i];
         if (edge_det[i] && (win_cnt != '0)) begin
            if (cnt[i] == '1)
               ovf_nxt[i] = 1'b1;
            else
               cnt_nxt[i] = cnt[i] + C_DWIDTH'(1);
         end
         data_nxt[i*C_DWIDTH +: C_DWIDTH] = cnt_nxt[i];
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state   <= S_IDLE;
         O_busy  <= 1'b0;
         O_valid <= 1'b0;
         O_data  <= '0;
         O_ovf   <= '0;
         win_cnt <= '0;
         ovf_w   <= '0;
         for (int unsigned i = 0; i < C_NCH; i++) cnt[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (I_start) begin
                  for (int unsigned i = 0; i < C_NCH; i++) cnt[i] <= '0;
                  ovf_w   <= '0;
                  win_cnt <= I_win_len;
                  state   <= S_COUNT;
               end
            end
            S_COUNT: begin
               for (int unsigned i = 0; i < C_NCH; i++) cnt[i] <= cnt_nxt[i];
               ovf_w  <= ovf_nxt;
               O_busy <= !finish;
               if (finish) begin
                  win_cnt <= '0;
                  O_data  <= data_nxt;
                  O_ovf   <= ovf_nxt;
                  O_valid <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  win_cnt <= win_cnt - C_WWIDTH'(1);
               end
            end
            S_DONE: begin
               if (I_ack) begin
                  O_valid <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MEAS_OSC_CMP_EN
   logic [C_NCH-2:0] resp_nxt;

   always_comb begin
      resp_nxt = '0;
      for (int unsigned i = 0; i < C_NCH - 1; i++)
         resp_nxt[i] = (cnt_nxt[i] > cnt_nxt[i+1]) && !ovf_nxt[i] && !ovf_nxt[i+1];
   end

   always_ff @(posedge I_clk) begin
      if (I_rst)
         O_resp <= '0;
      else if (finish)
         O_resp <= resp_nxt;
   end
`else
   assign O_resp = '0;
`endif

endmodule
